// File: rtl/conv_win_sched.sv
// conv_win_sched: read-side scheduler for the four-bank convolution line buffer.
// Tracks which banks hold a complete row, sweeps the three banks of the current
// 3-row band column by column, and assembles 3x3 windows into a 2-entry output
// FIFO behind a valid/ready handshake. Retired banks go back to the writer via mem_used.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               frame start pulse (honoured only when idle)
//   cfg_width/height    frame size, latched on an accepted start
//   mem_bank_full[i]    bank i has just received its last column
//   mem_used[i]         one-cycle release pulse for bank i
//   mb_rd_addr          per-bank column read address, bank i at [XB*i +: XB]
//   pix_data            per-bank read data, one cycle after the address, bank i at [PB*i +: PB]
//   win_valid/ready     window handshake
//   win_data            pixel k = 3*r+c at [PB*k +: PB], r=0 top row, c=0 left column
//   win_row/win_col     output coordinates of the head window
//   busy, done          not idle / one-cycle frame-complete pulse
// Optional: define CONV_WIN_SCHED_PERF_EN to add perf_stall and perf_wait counters.
module conv_win_sched #(
    parameter int XB = 10,
    parameter int YB = 10,
    parameter int PB = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XB-1:0]     cfg_width,
    input  logic [YB-1:0]     cfg_height,
    input  logic [3:0]        mem_bank_full,
    output logic [3:0]        mem_used,
    output logic [4*XB-1:0]   mb_rd_addr,
    input  logic [4*PB-1:0]   pix_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [9*PB-1:0]   win_data,
    output logic [YB-1:0]     win_row,
    output logic [XB-1:0]     win_col,
    output logic              busy,
    output logic              done
`ifdef CONV_WIN_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_wait
`endif
);
    localparam int EW = 9*PB + YB + XB;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SWEEP, S_DRAIN, S_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      filled_q, filled_d;
    logic [1:0]      tb_q, tb_d;
    logic [YB-1:0]   out_row_q, out_row_d;
    logic [XB-1:0]   w_m1_q, w_m1_d;
    logic [YB-1:0]   h_m3_q, h_m3_d;
    logic [XB-1:0]   col_q, col_d;
    logic            rd_vld_q, rd_vld_d;
    logic [XB-1:0]   rd_col_q, rd_col_d;
    logic [3*PB-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [EW-1:0]   e0_q, e0_d, e1_q, e1_d;
    logic [3:0]      mem_used_q, mem_used_d;
    logic            done_q, done_d;
`ifdef CONV_WIN_SCHED_PERF_EN
    logic [31:0]     perf_stall_q, perf_stall_d, perf_wait_q, perf_wait_d;
`endif

    logic [3:0]      band_mask;
    logic            pop, push, issue;
    logic [1:0]      cnt_p;
    logic [3*PB-1:0] newc;
    logic [9*PB-1:0] win_new;
    logic [EW-1:0]   e_new;

    always_comb begin
        band_mask = '0;
        newc = '0;
        win_new = '0;
        for (int r = 0; r < 3; r++) begin
            band_mask[tb_q + 2'(r)] = 1'b1;
            newc[PB*r +: PB] = pix_data[PB*int'(tb_q + 2'(r)) +: PB];
        end
        // Two held columns plus the column returning this cycle form the window.
        for (int r = 0; r < 3; r++) begin
            win_new[PB*(3*r)   +: PB] = sh0_q[PB*r +: PB];
            win_new[PB*(3*r+1) +: PB] = sh1_q[PB*r +: PB];
            win_new[PB*(3*r+2) +: PB] = newc[PB*r +: PB];
        end
        pop   = (cnt_q != 2'd0) && win_ready;
        cnt_p = cnt_q - {1'b0, pop};
        // Credit: post-pop occupancy plus the read in flight must leave room.
        issue = (state_q == S_SWEEP) && ((cnt_p + {1'b0, rd_vld_q}) < 2'd2);
        push  = rd_vld_q && (rd_col_q >= XB'(2));
        e_new = {out_row_q, rd_col_q - XB'(2), win_new};
        mb_rd_addr = '0;
        for (int b = 0; b < 4; b++)
            if (state_q == S_SWEEP && band_mask[b]) mb_rd_addr[XB*b +: XB] = col_q;
    end

    always_comb begin
        state_d    = state_q;
        tb_d       = tb_q;
        out_row_d  = out_row_q;
        w_m1_d     = w_m1_q;
        h_m3_d     = h_m3_q;
        col_d      = col_q;
        mem_used_d = '0;
        done_d     = 1'b0;
        filled_d   = (filled_q & ~mem_used_q) | mem_bank_full;
        rd_vld_d   = issue;
        rd_col_d   = issue ? col_q : rd_col_q;
        sh0_d      = rd_vld_q ? sh1_q : sh0_q;
        sh1_d      = rd_vld_q ? newc : sh1_q;
        e0_d       = pop ? e1_q : e0_q;
        e1_d       = e1_q;
        if (push && cnt_p == 2'd0) e0_d = e_new;
        if (push && cnt_p != 2'd0) e1_d = e_new;
        cnt_d      = cnt_p + {1'b0, push};
        case (state_q)
            S_IDLE: if (start) begin
                if (cfg_width < XB'(3) || cfg_height < YB'(3)) begin
                    done_d = 1'b1;
                end else begin
                    w_m1_d    = cfg_width - XB'(1);
                    h_m3_d    = cfg_height - YB'(3);
                    out_row_d = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: if ((filled_q & band_mask) == band_mask) begin
                state_d = S_SWEEP;
                col_d   = '0;
                sh0_d   = '0;
                sh1_d   = '0;
            end
            S_SWEEP: if (issue) begin
                col_d = col_q + XB'(1);
                if (col_q == w_m1_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Outputs are registered, so the release decision is made one cycle early.
                done_d     = (out_row_q == h_m3_q);
                mem_used_d = done_d ? band_mask : 4'b0001 << tb_q;
                state_d    = S_RELEASE;
            end
            S_RELEASE: begin
                // After the last band the writer continues at the bank following the band.
                tb_d      = done_q ? tb_q + 2'd3 : tb_q + 2'd1;
                out_row_d = done_q ? out_row_q : out_row_q + YB'(1);
                state_d   = done_q ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CONV_WIN_SCHED_PERF_EN
        perf_stall_d = perf_stall_q + 32'((cnt_q != 2'd0) && !win_ready && !(&perf_stall_q));
        perf_wait_d  = perf_wait_q + 32'((state_q == S_WAIT) && !(&perf_wait_q));
        if (state_q == S_IDLE && start) begin
            perf_stall_d = '0;
            perf_wait_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            filled_q   <= '0;
            tb_q       <= '0;
            out_row_q  <= '0;
            w_m1_q     <= '0;
            h_m3_q     <= '0;
            col_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_col_q   <= '0;
            sh0_q      <= '0;
            sh1_q      <= '0;
            cnt_q      <= '0;
            e0_q       <= '0;
            e1_q       <= '0;
            mem_used_q <= '0;
            done_q     <= 1'b0;
`ifdef CONV_WIN_SCHED_PERF_EN
            perf_stall_q <= '0;
            perf_wait_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            filled_q   <= filled_d;
            tb_q       <= tb_d;
            out_row_q  <= out_row_d;
            w_m1_q     <= w_m1_d;
            h_m3_q     <= h_m3_d;
            col_q      <= col_d;
            rd_vld_q   <= rd_vld_d;
            rd_col_q   <= rd_col_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            cnt_q      <= cnt_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            mem_used_q <= mem_used_d;
            done_q     <= done_d;
`ifdef CONV_WIN_SCHED_PERF_EN
            perf_stall_q <= perf_stall_d;
            perf_wait_q  <= perf_wait_d;
`endif
        end
    end

    assign mem_used  = mem_used_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign win_valid = (cnt_q != 2'd0);
    assign {win_row, win_col, win_data} = e0_q;
`ifdef CONV_WIN_SCHED_PERF_EN
    assign perf_stall = perf_stall_q;
    assign perf_wait  = perf_wait_q;
`endif
endmodule
